// File: rtl/spi_slave_if.sv
// Pin, configuration and receive-handshake bundle between spi_slave and its surroundings.
interface spi_slave_if;
    logic       tr_en;
    logic       cpol;
    logic       cpha;
    logic       msb_lsb;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;
    logic       frame_err;
    logic       busy;
    logic       sck;
    logic       cs;
    logic       sdi;
    logic       sdo;

    modport slave (
        input  tr_en, cpol, cpha, msb_lsb, tx_data, rx_ack, sck, cs, sdi,
        output rx_data, rx_valid, overrun, frame_err, busy, sdo
    );

    modport master (
        output tr_en, cpol, cpha, msb_lsb, tx_data, rx_ack, sck, cs, sdi,
        input  rx_data, rx_valid, overrun, frame_err, busy, sdo
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled sck/cs/sdi, one 8-bit word per cs-low frame, all CPOL/CPHA modes.
// Define SPI_SLAVE_SVA_EN to compile in protocol assertions and covers.
module spi_slave (
    input  logic       clk,
    input  logic       resetn,
    spi_slave_if.slave bus
);
    typedef enum logic [1:0] { IDLE, SHIFT, HOLD } state_t;

    state_t     state;
    logic       sck_m, sck_s, sck_q;
    logic       cs_m, cs_s, cs_q;
    logic       sdi_m, sdi_s;
    logic       cpol_l, cpha_l, msb_l, first_drive;
    logic [7:0] rx_sr, tx_sr;
    logic [3:0] bit_cnt;
    logic       sdo_r, rx_valid_r, overrun_r, frame_err_r, busy_r;
    logic [7:0] rx_data_r;

    logic       sck_edge, lead_edge, trail_edge, sample_edge, drive_edge;
    logic       cs_fall, cs_rise, next_tx_bit;
    logic [7:0] tx_shifted, rx_shifted;

    // The third sck register exists only to detect edges of the synchronized clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {sck_m, sck_s, sck_q} <= 3'b000;
            {cs_m, cs_s, cs_q}    <= 3'b111;
            {sdi_m, sdi_s}        <= 2'b00;
        end else begin
            sck_m <= bus.sck;
            sck_s <= sck_m;
            sck_q <= sck_s;
            cs_m  <= bus.cs;
            cs_s  <= cs_m;
            cs_q  <= cs_s;
            sdi_m <= bus.sdi;
            sdi_s <= sdi_m;
        end
    end

    assign sck_edge    = sck_s != sck_q;
    assign lead_edge   = sck_edge && (sck_s != cpol_l);
    assign trail_edge  = sck_edge && (sck_s == cpol_l);
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign drive_edge  = cpha_l ? lead_edge : trail_edge;
    assign cs_fall     = cs_q && !cs_s;
    assign cs_rise     = !cs_q && cs_s;
    assign next_tx_bit = msb_l ? tx_sr[7] : tx_sr[0];
    assign tx_shifted  = msb_l ? {tx_sr[6:0], 1'b0} : {1'b0, tx_sr[7:1]};
    assign rx_shifted  = msb_l ? {rx_sr[6:0], sdi_s} : {sdi_s, rx_sr[7:1]};

    // Completion is taken the cycle after the 8th sample, so a pending byte beats a racing cs rise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            msb_l       <= 1'b0;
            first_drive <= 1'b0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'h00;
            bit_cnt     <= 4'd0;
            sdo_r       <= 1'b1;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (!bus.tr_en) begin
            state       <= IDLE;
            cpol_l      <= 1'b0;
            cpha_l      <= 1'b0;
            msb_l       <= 1'b0;
            first_drive <= 1'b0;
            rx_sr       <= 8'h00;
            tx_sr       <= 8'h00;
            bit_cnt     <= 4'd0;
            sdo_r       <= 1'b1;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (bus.rx_ack) begin
                rx_valid_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    sdo_r <= 1'b1;
                    if (cs_fall) begin
                        state       <= SHIFT;
                        busy_r      <= 1'b1;
                        cpol_l      <= bus.cpol;
                        cpha_l      <= bus.cpha;
                        msb_l       <= bus.msb_lsb;
                        tx_sr       <= bus.tx_data;
                        first_drive <= !bus.cpha;
                        bit_cnt     <= 4'd0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == 4'd8) begin
                        state      <= HOLD;
                        rx_data_r  <= rx_sr;
                        rx_valid_r <= 1'b1;
                        if (rx_valid_r && !bus.rx_ack) begin
                            overrun_r <= 1'b1;
                        end
                    end else if (cs_rise) begin
                        state       <= IDLE;
                        busy_r      <= 1'b0;
                        sdo_r       <= 1'b1;
                        frame_err_r <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            rx_sr   <= rx_shifted;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        if (first_drive || drive_edge) begin
                            sdo_r       <= next_tx_bit;
                            tx_sr       <= tx_shifted;
                            first_drive <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (cs_s) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        sdo_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sdo       = sdo_r;
    assign bus.rx_data   = rx_data_r;
    assign bus.rx_valid  = rx_valid_r;
    assign bus.overrun   = overrun_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = busy_r;

`ifdef SPI_SLAVE_SVA_EN
    a_reset_values: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        $past(!resetn || !bus.tr_en) |-> (sdo_r && rx_data_r == 8'h00 && !rx_valid_r && !overrun_r && !frame_err_r && !busy_r));
    a_no_x_rx_data: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        rx_valid_r |-> !$isunknown(rx_data_r));
    a_idle_to_shift: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        (state == IDLE && cs_fall) |=> state == SHIFT);
    a_shift_to_hold: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        (state == SHIFT && bit_cnt == 4'd8) |=> state == HOLD);
    a_hold_to_idle: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        (state == HOLD && cs_s) |=> state == IDLE);
    a_sdo_idle: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        (state == IDLE) |-> sdo_r);
    a_frame_err_pulse: assert property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        frame_err_r |=> !frame_err_r);
    c_byte_done: cover property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        state == SHIFT && bit_cnt == 4'd8);
    c_abort: cover property (@(posedge clk) disable iff (!resetn || !bus.tr_en)
        frame_err_r);
`else
    // Properties are left out of this build; behaviour is unchanged.
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave; the bench plays the SPI master with a 6-clk half period.
module tb_spi_slave;
    localparam int HP = 6;
    localparam logic [12:0] RST_VEC = {1'b1, 8'h00, 4'b0000};

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    spi_slave_if bus ();

    spi_slave dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [12:0] out_vec();
        return {bus.sdo, bus.rx_data, bus.rx_valid, bus.overrun, bus.frame_err, bus.busy};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Covers the HP clocks following the 8th sampling edge; optionally acks in the completion cycle.
    task automatic done_window(input logic ack);
        wait_clk(3);
        if (ack) bus.rx_ack = 1'b1;
        wait_clk(1);
        bus.rx_ack = 1'b0;
        wait_clk(HP - 4);
    endtask

    task automatic spi_bits(input logic pol, input logic pha, input logic msb, input logic [7:0] tx,
                            input logic [7:0] mosi, input int nbits, input logic ack_at_done,
                            output logic [7:0] miso);
        miso = 8'h00;
        bus.cpol = pol;
        bus.cpha = pha;
        bus.msb_lsb = msb;
        bus.tx_data = tx;
        bus.sck = pol;
        wait_clk(4);
        bus.cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = msb ? mosi[7 - i] : mosi[i];
            if (!pha) bus.sdi = b;
            wait_clk(HP);
            bus.sck = ~pol;
            if (pha) bus.sdi = b;
            else miso = msb ? {miso[6:0], bus.sdo} : {bus.sdo, miso[7:1]};
            if (!pha && i == 7) done_window(ack_at_done);
            else wait_clk(HP);
            bus.sck = pol;
            if (pha) miso = msb ? {miso[6:0], bus.sdo} : {bus.sdo, miso[7:1]};
        end
        if (pha && nbits == 8) done_window(ack_at_done);
        else wait_clk(HP);
    endtask

    task automatic cs_release(output int err_cycles, output logic busy4);
        bus.cs = 1'b1;
        bus.sdi = 1'b0;
        err_cycles = 0;
        busy4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            wait_clk(1);
            if (bus.frame_err) err_cycles++;
            if (k == 4) busy4 = bus.busy;
        end
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        wait_clk(1);
        bus.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        wait_clk(3);
        checks++; if (out_vec() !== RST_VEC) begin errors++; $display("[TB] FAIL reset_held: got %h, expected %h", out_vec(), RST_VEC); end
        resetn = 1'b1;
        wait_clk(3);
        checks++; if (out_vec() !== RST_VEC) begin errors++; $display("[TB] FAIL reset_released: got %h, expected %h", out_vec(), RST_VEC); end
    endtask

    task automatic test_sdo_latency();
        int err; logic b4;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.msb_lsb = 1'b1; bus.tx_data = 8'h3C; bus.sck = 1'b0;
        wait_clk(2);
        bus.cs = 1'b0;
        wait_clk(3);
        checks++; if (bus.sdo !== 1'b1) begin errors++; $display("[TB] FAIL sdo_before_first_bit: got %b, expected 1", bus.sdo); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_cs_fall: got %b, expected 1", bus.busy); end
        wait_clk(1);
        checks++; if (bus.sdo !== 1'b0) begin errors++; $display("[TB] FAIL sdo_first_bit_at_4clk: got %b, expected 0", bus.sdo); end
        cs_release(err, b4);
        checks++; if (err !== 1) begin errors++; $display("[TB] FAIL zero_bit_abort_frame_err: got %0d cycles, expected 1", err); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL zero_bit_abort_rx_valid: got %b, expected 0", bus.rx_valid); end
    endtask

    task automatic test_mode0();
        logic [7:0] miso; int err; logic b4;
        spi_bits(1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL mode0_rx_data: got %h, expected a5", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL mode0_rx_valid: got %b, expected 1", bus.rx_valid); end
        checks++; if (miso !== 8'h3C) begin errors++; $display("[TB] FAIL mode0_miso: got %h, expected 3c", miso); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL mode0_overrun: got %b, expected 0", bus.overrun); end
        checks++; if (err !== 0) begin errors++; $display("[TB] FAIL mode0_frame_err: got %0d cycles, expected 0", err); end
        checks++; if (b4 !== 1'b0) begin errors++; $display("[TB] FAIL mode0_busy_after_cs: got %b, expected 0", b4); end
        checks++; if (bus.sdo !== 1'b1) begin errors++; $display("[TB] FAIL mode0_sdo_idle: got %b, expected 1", bus.sdo); end
        ack_pulse();
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mode0_ack_clears: got %b, expected 0", bus.rx_valid); end
    endtask

    task automatic test_mode3();
        logic [7:0] miso; int err; logic b4;
        spi_bits(1'b1, 1'b1, 1'b0, 8'h5A, 8'h81, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("[TB] FAIL mode3_rx_data: got %h, expected 81", bus.rx_data); end
        checks++; if (miso !== 8'h5A) begin errors++; $display("[TB] FAIL mode3_miso: got %h, expected 5a", miso); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL mode3_rx_valid: got %b, expected 1", bus.rx_valid); end
        checks++; if (bus.sdo !== 1'b1) begin errors++; $display("[TB] FAIL mode3_sdo_idle: got %b, expected 1", bus.sdo); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        logic [7:0] miso; int err; logic b4;
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8, 1'b0, miso);
        cs_release(err, b4);
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h22, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_data !== 8'h22) begin errors++; $display("[TB] FAIL overrun_rx_data: got %h, expected 22", bus.rx_data); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b, expected 1", bus.overrun); end
        ack_pulse();
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL overrun_ack_rx_valid: got %b, expected 0", bus.rx_valid); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b, expected 1", bus.overrun); end
    endtask

    task automatic test_abort();
        logic [7:0] miso; int err; logic b4;
        spi_bits(1'b0, 1'b0, 1'b1, 8'hFF, 8'hF0, 3, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (err !== 1) begin errors++; $display("[TB] FAIL abort_frame_err_width: got %0d cycles, expected 1", err); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rx_valid: got %b, expected 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h22) begin errors++; $display("[TB] FAIL abort_rx_data_kept: got %h, expected 22", bus.rx_data); end
        checks++; if (b4 !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy_4clk: got %b, expected 0", b4); end
    endtask

    task automatic test_same_cycle_ack();
        logic [7:0] miso; int err; logic b4;
        bus.tr_en = 1'b0;
        wait_clk(1);
        checks++; if (out_vec() !== RST_VEC) begin errors++; $display("[TB] FAIL tr_en_clear_idle: got %h, expected %h", out_vec(), RST_VEC); end
        bus.tr_en = 1'b1;
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h12, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_pre_valid: got %b, expected 1", bus.rx_valid); end
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h34, 8, 1'b1, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_rx_valid: got %b, expected 1", bus.rx_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL same_cycle_overrun: got %b, expected 0", bus.overrun); end
        checks++; if (bus.rx_data !== 8'h34) begin errors++; $display("[TB] FAIL same_cycle_rx_data: got %h, expected 34", bus.rx_data); end
        ack_pulse();
    endtask

    task automatic test_disturbance();
        logic [7:0] miso; int err; logic b4;
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8, 1'b0, miso);
        cs_release(err, b4);
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 4, 1'b0, miso);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_mid_frame: got %b, expected 1", bus.busy); end
        resetn = 1'b0;
        #1;
        checks++; if (out_vec() !== RST_VEC) begin errors++; $display("[TB] FAIL async_reset_mid_frame: got %h, expected %h", out_vec(), RST_VEC); end
        bus.cs = 1'b1;
        bus.sck = 1'b0;
        wait_clk(3);
        resetn = 1'b1;
        wait_clk(1);
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8, 1'b0, miso);
        cs_release(err, b4);
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h55, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("[TB] FAIL pre_tr_en_overrun: got %b, expected 1", bus.overrun); end
        spi_bits(1'b0, 1'b0, 1'b1, 8'h00, 8'h99, 4, 1'b0, miso);
        bus.tr_en = 1'b0;
        wait_clk(1);
        checks++; if (out_vec() !== RST_VEC) begin errors++; $display("[TB] FAIL tr_en_drop_mid_frame: got %h, expected %h", out_vec(), RST_VEC); end
        bus.tr_en = 1'b1;
        wait_clk(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_with_cs_low: got %b, expected 0", bus.busy); end
        cs_release(err, b4);
        checks++; if (err !== 0) begin errors++; $display("[TB] FAIL no_frame_err_after_tr_en: got %0d cycles, expected 0", err); end
        spi_bits(1'b0, 1'b1, 1'b1, 8'h96, 8'hC3, 8, 1'b0, miso);
        cs_release(err, b4);
        checks++; if (bus.rx_data !== 8'hC3) begin errors++; $display("[TB] FAIL recover_rx_data: got %h, expected c3", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL recover_rx_valid: got %b, expected 1", bus.rx_valid); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("[TB] FAIL recover_overrun: got %b, expected 0", bus.overrun); end
        checks++; if (miso !== 8'h96) begin errors++; $display("[TB] FAIL recover_miso: got %h, expected 96", miso); end
    endtask

    initial begin
        resetn      = 1'b0;
        bus.tr_en   = 1'b1;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.msb_lsb = 1'b1;
        bus.tx_data = 8'h00;
        bus.rx_ack  = 1'b0;
        bus.sck     = 1'b0;
        bus.cs      = 1'b1;
        bus.sdi     = 1'b0;
        $display("[TB] starting spi_slave directed tests");
        test_reset();
        test_sdo_latency();
        test_mode0();
        test_mode3();
        test_overrun();
        test_abort();
        test_same_cycle_ack();
        test_disturbance();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
